// File: rtl/trid_pkg.sv
// Shared constants and types for the transaction-ID tracker.
// Per-entry lifecycle: FREE -> PENDING (allocated) -> READY (response back) -> FREE (drained).
package trid_pkg;

  localparam int TRIDNUM = 16;
  localparam int TRIDBIT = 4;
  localparam int TAG_W   = 8;

  typedef logic [TRIDBIT-1:0] trid_t;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    PENDING = 2'd1,
    READY   = 2'd2
  } trid_state_e;

endpackage

// File: rtl/trid_free_pick.sv
// Lowest-index priority encoder over the FREE vector.
// Produces the index of the first free entry and an any-free flag.
module trid_free_pick #(
  parameter int TRIDNUM = 16,
  parameter int TRIDBIT = 4
) (
  input  logic [TRIDNUM-1:0] free_vec,
  output logic [TRIDBIT-1:0] pick_idx,
  output logic               pick_any
);

  // scan from the top down so the lowest set bit is the last one to win
  always_comb begin
    pick_idx = {TRIDBIT{1'b0}};
    pick_any = |free_vec;
    for (int i = TRIDNUM - 1; i >= 0; i--) begin
      pick_idx = free_vec[i] ? TRIDBIT'(i) : pick_idx;
    end
  end

endmodule

// File: rtl/trid_tracker.sv
// Transaction-ID tracker: allocates TRIDs, tracks responses, drives the
// ready vector to the select mux and frees entries on the drain handshake.
module trid_tracker
  import trid_pkg::*;
#(
  parameter int TRIDNUM = trid_pkg::TRIDNUM,
  parameter int TRIDBIT = trid_pkg::TRIDBIT,
  parameter int TAG_W   = trid_pkg::TAG_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_alloc_req,
  input  logic [TAG_W-1:0]   i_alloc_tag,
  output logic               o_alloc_gnt,
  output logic [TRIDBIT-1:0] o_alloc_trid,
  output logic               o_full,
  input  logic               i_rsp_valid,
  input  logic [TRIDBIT-1:0] i_rsp_trid,
  output logic [TRIDNUM-1:0] o_ready,
  input  logic               i_drain_en,
  input  logic [TRIDBIT-1:0] i_drain_sel,
  output logic [TAG_W-1:0]   o_drain_tag,
  output logic [TRIDBIT:0]   o_count,
  output logic               o_err
);

  localparam int CNT_W = TRIDBIT + 1;

  trid_state_e        state_r [TRIDNUM];
  logic [TAG_W-1:0]   tag_r   [TRIDNUM];
  logic [CNT_W-1:0]   count_r;
  logic               err_r;

  logic [TRIDNUM-1:0] free_vec_s;
  logic [TRIDNUM-1:0] ready_vec_s;
  logic [TRIDBIT-1:0] pick_idx_s;
  logic               pick_any_s;
  logic               alloc_gnt_s;
  logic               rsp_ok_s;
  logic               rsp_err_s;
  logic               drain_ok_s;
  logic               drain_err_s;
  logic [CNT_W-1:0]   count_nxt_s;

  // decode registered per-entry state into FREE and READY bit vectors
  always_comb begin
    free_vec_s  = {TRIDNUM{1'b0}};
    ready_vec_s = {TRIDNUM{1'b0}};
    for (int n = 0; n < TRIDNUM; n++) begin
      free_vec_s[n]  = (state_r[n] == FREE);
      ready_vec_s[n] = (state_r[n] == READY);
    end
  end

  trid_free_pick #(
    .TRIDNUM (TRIDNUM),
    .TRIDBIT (TRIDBIT)
  ) u_free_pick (
    .free_vec (free_vec_s),
    .pick_idx (pick_idx_s),
    .pick_any (pick_any_s)
  );

  // handshake qualification; FREE set comes from registers so a same-cycle
  // drain never feeds the grant path
  always_comb begin
    alloc_gnt_s = i_alloc_req & pick_any_s;
    rsp_ok_s    = i_rsp_valid & (state_r[i_rsp_trid] == PENDING);
    rsp_err_s   = i_rsp_valid & ~rsp_ok_s;
    drain_ok_s  = i_drain_en & (state_r[i_drain_sel] == READY);
    drain_err_s = i_drain_en & ~drain_ok_s;
    count_nxt_s = count_r + CNT_W'(alloc_gnt_s) - CNT_W'(drain_ok_s);
  end

  // entry state, tag storage, occupancy and error pulse registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int n = 0; n < TRIDNUM; n++) begin
        state_r[n] <= FREE;
        tag_r[n]   <= {TAG_W{1'b0}};
      end
      count_r <= {CNT_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      if (alloc_gnt_s) begin
        state_r[pick_idx_s] <= PENDING;
        tag_r[pick_idx_s]   <= i_alloc_tag;
      end
      if (rsp_ok_s) begin
        state_r[i_rsp_trid] <= READY;
      end
      if (drain_ok_s) begin
        state_r[i_drain_sel] <= FREE;
      end
      count_r <= count_nxt_s;
      err_r   <= rsp_err_s | drain_err_s;
    end
  end

  assign o_alloc_gnt  = alloc_gnt_s;
  assign o_alloc_trid = pick_idx_s;
  assign o_full       = (count_r == CNT_W'(TRIDNUM));
  assign o_ready      = ready_vec_s;
  assign o_drain_tag  = tag_r[i_drain_sel];
  assign o_count      = count_r;
  assign o_err        = err_r;

endmodule

// File: doc/trid_tracker.md
Name: trid_tracker

Overview:
- Producer and consumer end of the ready-vector/select interface of the relational cache's transaction-ID select mux.
- Allocates free transaction IDs (TRIDs) to outgoing requests and stores a per-TRID tag.
- Marks a TRID ready when its response returns and drives the 16-bit ready vector into the select mux.
- Accepts the mux's enable/select back as the drain handshake, then frees the TRID and presents its tag.

Parameters:
TRIDNUM, 16, number of transaction IDs tracked (one ready bit each)
TRIDBIT, 4, TRID index width, log2(TRIDNUM)
TAG_W, 8, width of the per-TRID tag stored at allocation

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  reset, synchronous, active-high
i_alloc_req  input  1  request a new TRID this cycle
i_alloc_tag  input  TAG_W  tag stored with the granted TRID
o_alloc_gnt  output  1  allocation accepted this cycle
o_alloc_trid  output  TRIDBIT  granted TRID, valid when o_alloc_gnt=1
o_full  output  1  no FREE TRID
i_rsp_valid  input  1  response returned
i_rsp_trid  input  TRIDBIT  TRID of the returned response
o_ready  output  TRIDNUM  ready vector to the select mux; bit n=1 means TRID n is READY
i_drain_en  input  1  enable from the select mux (any ready bit set)
i_drain_sel  input  TRIDBIT  TRID chosen by the select mux
o_drain_tag  output  TAG_W  tag of TRID i_drain_sel (combinational read)
o_count  output  TRIDBIT+1  number of non-FREE TRIDs
o_err  output  1  one-cycle pulse on a protocol violation

Behaviour:
- Each TRID has a 2-bit state, all held in registers:
  - FREE to PENDING on an allocation grant.
  - PENDING to READY on a valid response.
  - READY to FREE on a drain.
- Reset (synchronous, i_rst=1 at the edge):
  - All states become FREE and all tags become 0.
  - o_ready=0, o_count=0, o_err=0, o_full=0, o_alloc_gnt=0.
  - Reset wins over every other input in the same cycle, including mid-transaction; outstanding TRIDs are dropped silently.
- Allocation (combinational grant, from registered state):
  - o_alloc_gnt = i_alloc_req & ~o_full.
  - o_alloc_trid = lowest-index FREE TRID; it is 0 when o_full=1.
  - On grant, at the next edge: that entry becomes PENDING and the tag is written.
  - A request while o_full=1 is refused (o_alloc_gnt=0). It is not an error. The requester holds or retries.
- Response:
  - i_rsp_valid with i_rsp_trid in PENDING: the entry becomes READY at the next edge, so o_ready[n] rises one cycle after the response.
  - If the target is FREE or READY: o_err pulses the next cycle and the state is unchanged.
- Drain:
  - o_ready is the registered READY set, fed directly to the select mux, which returns i_drain_en/i_drain_sel in the same cycle.
  - i_drain_en=1 with i_drain_sel in READY: the tag is valid on o_drain_tag in that cycle, and the entry becomes FREE at the next edge.
  - Drain of a non-READY entry: o_err pulses, no state change.
  - One drain per cycle maximum.
- Simultaneous events:
  - Alloc, response and drain may all occur in one cycle on distinct TRIDs.
  - A TRID freed by a drain is not allocatable until the cycle after; the FREE set is taken from registered state. This removes any comb path from i_drain_* to o_alloc_*.
  - A response to a TRID being granted in the same cycle is an error, because the TRID is still FREE.
  - If the response and a drain-violation both occur, o_err=1 (the errors are OR'ed).
- Count: o_count_next = o_count + gnt - valid_drain. The width TRIDBIT+1 holds 0..TRIDNUM with no wrap. o_full = (o_count == TRIDNUM).
- o_err is a registered pulse, exactly one cycle per violating cycle.

Decomposition:
- Package trid_pkg:
  - TRIDNUM and TRIDBIT constants.
  - The trid_t typedef.
  - Enum trid_state_e {FREE, PENDING, READY}.
- One sub-module is natural: trid_free_pick, a lowest-index priority encoder over the FREE vector producing an index and an any-free flag. It is parameterised on TRIDNUM and written as a loop, not a case list.

Test Plan:
- Reset, then 16 back-to-back allocs with tags 0x10..0x1F:
  - TRIDs 0..15 are granted in order.
  - o_count=16 and o_full=1.
  - A 17th request gets o_alloc_gnt=0 and o_err=0.
- Responses to TRIDs 3 and 9:
  - o_ready=0x0208 one cycle later.
  - With the mux model, drain of sel=9 gives o_drain_tag=0x19.
  - The next cycle o_ready=0x0008 and o_count=15.
- Same cycle: drain of TRID 9 and an alloc request with all other TRIDs busy:
  - o_alloc_gnt=0.
  - The next cycle the grant returns TRID 9.
- Response to FREE TRID 5, and a repeated response to READY TRID 3:
  - Each produces a one-cycle o_err pulse.
  - States and o_ready are unchanged.
- i_rst asserted with 4 PENDING and 2 READY TRIDs:
  - After the next edge: o_ready=0, o_count=0, o_full=0.
  - The next alloc returns TRID 0 with its new tag.
- Random mix of alloc, response and drain for 10k cycles against a scoreboard:
  - No error pulses with legal stimulus.
  - o_count always equals the scoreboard occupancy.
